// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  localparam seg_t BCD_PATTERNS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    if (bcd <= 4'd9) begin
      seg = BCD_PATTERNS[bcd];
    end else begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexes four per-frame snapshotted BCD digits onto a common-anode display
// with leading-zero blanking, decimal points and blink. Define SEVENSEG_BRIGHTNESS_EN for the duty input.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 25000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  input  logic        blink,
`ifdef SEVENSEG_BRIGHTNESS_EN
  input  logic [2:0]  duty,
`endif
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int TICK_W  = $clog2(REFRESH_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [1:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  blink_phase_e       blink_phase_q, blink_phase_d;
  logic [15:0]        snapshot_q, snapshot_d;
  logic [3:0]         dp_snap_q, dp_snap_d;
  logic [3:0]         anode_q, anode_d;
  seg_t               seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [3:0] cur_digit;
  seg_t       dec_seg;
  logic       tick_wrap, frame_end, lz_blank, blanked, dark, lit_window;

  assign cur_digit = snapshot_q[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  assign tick_wrap = (tick_q == TICK_LAST);
  assign frame_end = tick_wrap && (idx_q == 2'd3);

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    tick_d        = tick_q + TICK_W'(1);
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    snapshot_d    = snapshot_q;
    dp_snap_d     = dp_snap_q;

    if (tick_wrap) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    // Only the frame boundary samples the inputs, so a changing count cannot tear.
    if (frame_end) begin
      snapshot_d = digits;
      dp_snap_d  = dp_mask;
    end

    if (!blink) begin
      frame_cnt_d   = '0;
      blink_phase_d = PHASE_ON;
    end else if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = (blink_phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  always_comb begin
    lz_blank = 1'b0;
    unique case (idx_q)
      2'd3:    lz_blank = (snapshot_q[15:12] == 4'd0);
      2'd2:    lz_blank = (snapshot_q[15:8] == 8'd0);
      2'd1:    lz_blank = (snapshot_q[15:4] == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end

  assign blanked = blank_lz && lz_blank;
  // Live blink level lets the display relight on the very next cycle after blink drops.
  assign dark    = blink && (blink_phase_q == PHASE_OFF);

`ifdef SEVENSEG_BRIGHTNESS_EN
  assign lit_window = int'(tick_q) < (((int'(duty) + 1) * REFRESH_DIV) / 8);
`else
  assign lit_window = 1'b1;
`endif

  always_comb begin
    anode_d = 4'b1111;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    if (!dark && !blanked) begin
      seg_d = dec_seg;
      dp_d  = ~dp_snap_q[idx_q];
      if (lit_window) begin
        anode_d[idx_q] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q        <= '0;
      idx_q         <= 2'd0;
      frame_cnt_q   <= '0;
      blink_phase_q <= PHASE_ON;
      snapshot_q    <= 16'h0000;
      dp_snap_q     <= 4'b0000;
      anode_q       <= 4'b1111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      snapshot_q    <= snapshot_d;
      dp_snap_q     <= dp_snap_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed, table-driven bench for sevenseg_scan_driver with REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_sevenseg_scan_driver;

  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = 4 * REFRESH_DIV;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        blink;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;

  // One frame worth of expectations: per digit lit flag, segments and active-low dp.
  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp_mask;
    logic            blz;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
    logic [3:0]      dp_n;
  } vec_t;

  vec_t vecs [8];
  vec_t zero_rec, dark_rec, rec_0123, rec_0999, rec_1234;

  sevenseg_scan_driver #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digits   (digits),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .blink    (blink),
`ifdef SEVENSEG_BRIGHTNESS_EN
    .duty     (3'd7),
`endif
    .anode    (anode),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " anode"}, 32'(anode), 32'h0000_000F);
    check({tag, " seg"},   32'(seg),   32'h0000_007F);
    check({tag, " dp"},    32'(dp),    32'h0000_0001);
  endtask

  // Steps `count` cycles of a frame starting at slot cycle `first`, checking each against e.
  task automatic run_cycles(input vec_t e, input int first, input int count, input string tag);
    int n;
    logic [3:0] exp_anode;
    for (int c = first; c < first + count; c++) begin
      step();
      n = c / REFRESH_DIV;
      exp_anode = e.lit[n] ? ~(4'b0001 << n) : 4'b1111;
      check($sformatf("%s c%0d anode", tag, c), 32'(anode), 32'(exp_anode));
      check($sformatf("%s c%0d seg", tag, c),   32'(seg),   32'(e.seg[n]));
      check($sformatf("%s c%0d dp", tag, c),    32'(dp),    32'(e.dp_n[n]));
    end
  endtask

  task automatic idle_frame();
    for (int c = 0; c < FRAME_CYC; c++) step();
  endtask

  task automatic apply(input vec_t v);
    digits   = v.digits;
    dp_mask  = v.dp_mask;
    blank_lz = v.blz;
  endtask

  initial begin
    zero_rec = '{16'h0000, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    dark_rec = '{16'h1234, 4'b0000, 1'b0, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
    rec_0123 = '{16'h0123, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h79, 7'h24, 7'h30}, 4'b1111};
    rec_0999 = '{16'h0999, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h10, 7'h10, 7'h10}, 4'b1111};
    rec_1234 = '{16'h1234, 4'b0000, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};

    vecs[0] = rec_1234;
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0050, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
    vecs[3] = '{16'h00C0, 4'b0010, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h3F, 7'h40}, 4'b1101};
    vecs[4] = '{16'h0008, 4'b0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'b1111};
    vecs[5] = '{16'h9F07, 4'b1001, 1'b1, 4'b1111, {7'h10, 7'h3F, 7'h40, 7'h78}, 4'b0110};
    vecs[6] = '{16'h0102, 4'b0000, 1'b1, 4'b0111, {7'h7F, 7'h79, 7'h40, 7'h24}, 4'b1111};
    vecs[7] = '{16'h0050, 4'b1111, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1100};

    reset    = 1'b1;
    digits   = 16'h0000;
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;
    blink    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs($sformatf("reset%0d", i));
    end

    // First frame after release still shows snapshot 0 while 1234 waits for the frame end.
    apply(vecs[0]);
    reset = 1'b0;
    run_cycles(zero_rec, 0, FRAME_CYC, "frame0");

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i]);
      if (i > 0) idle_frame();
      run_cycles(vecs[i], 0, FRAME_CYC, $sformatf("vec%0d", i));
    end

    // Digits change mid-frame: the rest of the frame keeps the old snapshot.
    apply(rec_0123);
    idle_frame();
    run_cycles(rec_0123, 0, 5, "tear_a");
    digits = 16'h0999;
    run_cycles(rec_0123, 5, FRAME_CYC - 5, "tear_b");
    run_cycles(rec_0999, 0, FRAME_CYC, "tear_next");

    // Blink over 8 frames: 2 lit, 2 dark, repeating.
    apply(rec_1234);
    idle_frame();
    blink = 1'b1;
    for (int f = 1; f <= 7; f++) begin
      if (((f - 1) / 2) % 2 == 0) run_cycles(rec_1234, 0, FRAME_CYC, $sformatf("blink_f%0d", f));
      else                        run_cycles(dark_rec, 0, FRAME_CYC, $sformatf("blink_f%0d", f));
    end
    run_cycles(dark_rec, 0, 6, "blink_f8");
    blink = 1'b0;
    run_cycles(rec_1234, 6, FRAME_CYC - 6, "blink_drop");
    run_cycles(rec_1234, 0, FRAME_CYC, "blink_after");

    // Reset during the digit 2 slot.
    run_cycles(rec_1234, 0, 9, "pre_rst");
    reset = 1'b1;
    step();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    run_cycles(zero_rec, 0, FRAME_CYC, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Downstream stage of the stopwatch.
- Consumes the four BCD display digits (Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds) and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Supports leading-zero blanking, per-digit decimal points, and a blink mode driven by the stopwatch's expiry/flash condition.
- Digits are snapshotted once per frame, so a count that changes mid-scan never tears across digits.

Parameters:
- REFRESH_DIV, 25000: clk cycles each digit is lit; must be ≥2.
- BLINK_FRAMES, 50: full 4-digit frames per blink half-period; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits  in  16  BCD digits; [15:12]=minutes (digit 3), [11:8]=tens of seconds, [7:4]=ones of seconds, [3:0]=tenths (digit 0).
- dp_mask  in  4  decimal point request per digit; bit n maps to digit n; 1=lit.
- blank_lz  in  1  1 enables leading-zero blanking.
- blink  in  1  level; 1 makes the whole display flash.
- anode  out  4  active-low digit enables; bit n maps to digit n.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.

Behaviour:
- Reset (clk edge with reset=1):
  - anode=4'b1111, seg=7'h7F, dp=1.
  - tick=0, idx=0, frame_cnt=0, blink_phase=ON, snapshot=16'h0000, dp_snap=4'b0000.
- Scan counters:
  - tick counts 0..REFRESH_DIV-1.
  - On tick wrap, idx advances 0→1→2→3→0.
  - The frame ends when tick=REFRESH_DIV-1 and idx=3.
- Snapshot: at the frame-end cycle, digits→snapshot and dp_mask→dp_snap. The next frame shows only the snapshot. Inputs are otherwise ignored.
- Outputs are registered, with 1-cycle latency from (idx, snapshot, blink_phase) to anode/seg/dp.
- For the current idx=n, value v=snapshot[4n+3:4n]:
  - v in 0..9: standard 7-seg pattern (0=7'h40 active-low, 8=7'h00).
  - v in 10..15: dash, segment g only (7'h3F).
  - dp = ~dp_snap[n].
- Leading-zero blanking applies when blank_lz=1 (sampled live):
  - Digit 3 is blank if v3=0.
  - Digit 2 is blank if v3=0 and v2=0.
  - Digit 1 is blank if v3=v2=v1=0.
  - Digit 0 is never blanked.
  - Blanked means that digit's anode stays 1 and seg=7'h7F for its slot. dp is also forced to 1.
- Blink:
  - While blink=0: blink_phase=ON and frame_cnt=0.
  - While blink=1: frame_cnt increments at each frame end. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - On the first frame after blink rises, the phase is ON.
  - In the OFF phase, anode=4'b1111 and seg/dp=all 1s; counters keep running.
- Only one anode bit is ever 0 in any cycle.
- Reset mid-frame returns to the reset state immediately. The first lit output appears the cycle after reset deasserts, showing digit 0 of snapshot 0 (a "0").
- If blink and frame end coincide, the frame end is processed first (the snapshot still loads).

Optional Feature:
- Macro SEVENSEG_BRIGHTNESS_EN.
- When defined:
  - Adds input `duty [2:0]`.
  - Within each digit slot, the anode is asserted only while tick < ((duty+1)*REFRESH_DIV)/8. Otherwise anode=4'b1111.
  - duty=7 gives full on.
  - seg/dp keep their values during the dark portion.
- When undefined: the port is absent and the full slot is lit.

Decomposition:
- Package sevenseg_pkg:
  - NUM_DIGITS=4.
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - Constant array of the ten BCD segment patterns.
  - Typedef for the 7-bit segment vector.
- Sub-module bcd_to_7seg: combinational decoder, 4-bit in to 7-bit active-low out, invalid codes give SEG_DASH. It is instantiated once on the muxed digit.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset held, then released with digits=16'h1234:
  - Cycles 1–4: anode=1110, seg=pattern(0) (snapshot still 0).
  - After the first frame end: digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1, in 4-cycle slots.
- digits=16'h0050, blank_lz=1:
  - Digit 3 and digit 2 slots have anode=1111.
  - Digit 1 shows 5 and digit 0 shows 0.
  - With blank_lz=0, all four digits are lit.
- digits changed from 16'h0123 to 16'h0999 during the idx=1 slot:
  - The remainder of the frame still shows 0123.
  - The next frame shows 0999.
- digits[7:4]=4'hC, dp_mask=4'b0010:
  - The digit 1 slot has seg=7'h3F and dp=0.
  - All other slots have dp=1.
- blink held 1 for 8 frames:
  - Frames 1–2 are lit, frames 3–4 are dark (anode=1111), frames 5–6 are lit, frames 7–8 are dark.
  - Dropping blink returns the display to lit within 1 cycle.
- Reset asserted during the idx=2 slot:
  - Next cycle: anode=1111, seg=7'h7F, dp=1.
  - Scanning restarts at idx=0.
